// File: rtl/io_writeback_arbiter.sv
// Sole register-file write-port driver: merges CPU writes with a FIFO of peripheral event writes.
// CPU passthrough is zero-latency; events write one cycle after acceptance at best; ev_ready drops when the FIFO is full.
module io_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        cpu_writeEnable,
  input  logic [4:0]  cpu_writeReg,
  input  logic [31:0] cpu_data,
  input  logic        ev_valid,
  input  logic [4:0]  ev_reg,
  input  logic [31:0] ev_data,
  output logic        ev_ready,
  output logic        cpu_stall,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [4:0]  fifo_count,
  output logic        ovf_sticky,
  output logic [7:0]  drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);
  localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_FORCE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  reg_addr;
    logic [31:0] dat;
  } ev_t;

  state_t        r_state;
  state_t        w_state_nxt;
  ev_t           r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic [4:0]    w_count_nxt;
  logic [7:0]    r_wait_cnt;
  logic [7:0]    w_wait_nxt;
  logic          r_ovf;
  logic [7:0]    r_drop_cnt;
  logic          w_accept;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  ev_t           w_head;

  assign ev_ready   = (r_count != DEPTH_C);
  assign fifo_count = r_count;
  assign ovf_sticky = r_ovf;
  assign drop_count = r_drop_cnt;

  assign w_accept = ev_valid && ev_ready;
  assign w_push   = w_accept && (ev_reg != 5'd0);
  assign w_drop   = w_accept && (ev_reg == 5'd0);
  assign w_head   = r_mem[r_rd_ptr];

  // Payload storage needs no reset: only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= ev_t'{ev_reg, ev_data};
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wait_cnt <= '0;
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (ev_valid && !ev_ready) r_ovf <= 1'b1;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) r_state <= ST_EMPTY;
    else            r_state <= w_state_nxt;
  end

  // Starvation counter only advances while an event is blocked by a CPU write.
  always_comb begin
    w_count_nxt = r_count + 5'(w_push) - 5'(w_pop);
    w_wait_nxt  = r_wait_cnt;
    if (w_pop || r_count == 5'd0)
      w_wait_nxt = 8'd0;
    else if (r_state == ST_PENDING && cpu_writeEnable && r_wait_cnt < LIMIT_C)
      w_wait_nxt = r_wait_cnt + 8'd1;
    if (w_count_nxt == 5'd0)
      w_state_nxt = ST_EMPTY;
    else if (w_wait_nxt == LIMIT_C)
      w_state_nxt = ST_FORCE;
    else
      w_state_nxt = ST_PENDING;
  end

  always_comb begin
    w_pop     = 1'b0;
    cpu_stall = 1'b0;
    case (r_state)
      ST_PENDING: w_pop = !cpu_writeEnable;
      ST_FORCE: begin
        w_pop     = 1'b1;
        cpu_stall = cpu_writeEnable;
      end
      default: w_pop = 1'b0;
    endcase
    if (w_pop) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = w_head.reg_addr;
      data_writeReg    = w_head.dat;
    end else begin
      ctrl_writeEnable = cpu_writeEnable;
      ctrl_writeReg    = cpu_writeEnable ? cpu_writeReg : 5'd0;
      data_writeReg    = cpu_writeEnable ? cpu_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_io_writeback_arbiter.sv
// Directed bench for io_writeback_arbiter: event writes are scoreboarded in acceptance order,
// CPU writes carry 0xC0 in the top data byte so the monitor can tell them apart.
module tb_io_writeback_arbiter;
  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        cpu_writeEnable;
  logic [4:0]  cpu_writeReg;
  logic [31:0] cpu_data;
  logic        ev_valid;
  logic [4:0]  ev_reg;
  logic [31:0] ev_data;
  logic        ev_ready;
  logic        cpu_stall;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  fifo_count;
  logic        ovf_sticky;
  logic [7:0]  drop_count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [36:0] exp_q [$];

  io_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(16)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .cpu_writeEnable(cpu_writeEnable), .cpu_writeReg(cpu_writeReg), .cpu_data(cpu_data),
    .ev_valid(ev_valid), .ev_reg(ev_reg), .ev_data(ev_data), .ev_ready(ev_ready),
    .cpu_stall(cpu_stall), .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .fifo_count(fifo_count), .ovf_sticky(ovf_sticky),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_ev(input logic [4:0] r, input logic [31:0] d);
    int n;
    n = 0;
    ev_valid = 1'b1;
    ev_reg   = r;
    ev_data  = d;
    while (!ev_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ev_accept_timeout", 64'(n < 200), 64'd1);
    if (r != 5'd0) exp_q.push_back({r, d});
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic cpu_set(input logic en, input logic [4:0] r);
    cpu_writeEnable = en;
    cpu_writeReg    = r;
    cpu_data        = {8'hC0, 19'd0, r};
  endtask

  // Scoreboard side: every non-CPU write must match the oldest accepted event.
  always @(negedge clock) begin
    logic [36:0] e;
    if (!ctrl_writeEnable)
      chk("idle_port_zero", {27'd0, ctrl_writeReg, data_writeReg}, 64'd0);
    else if (!ctrl_reset && data_writeReg[31:24] != 8'hC0) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_event_write", {27'd0, ctrl_writeReg, data_writeReg}, {27'd0, e});
      end
    end
  end

  initial begin
    int blocked;
    int n;
    ctrl_reset = 1'b1;
    ev_valid   = 1'b0;
    ev_reg     = '0;
    ev_data    = '0;
    cpu_set(1'b0, 5'd0);
    #2;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ev_ready", 64'(ev_ready), 64'd1);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_ovf_drop", {ovf_sticky, drop_count}, 64'd0);
    cpu_set(1'b1, 5'd3);
    #1;
    chk("rst_passthru_we", 64'(ctrl_writeEnable), 64'd1);
    chk("rst_passthru_reg", 64'(ctrl_writeReg), 64'd3);
    cpu_set(1'b0, 5'd0);
    tick();
    ctrl_reset = 1'b0;
    tick();

    // Single event, CPU idle
    chk("single_pre_count", 64'(fifo_count), 64'd0);
    send_ev(5'd5, 32'h0000_00A5);
    chk("single_count1", 64'(fifo_count), 64'd1);
    chk("single_we", 64'(ctrl_writeEnable), 64'd1);
    chk("single_reg", 64'(ctrl_writeReg), 64'd5);
    chk("single_data", 64'(data_writeReg), 64'h0000_00A5);
    tick();
    chk("single_count0", 64'(fifo_count), 64'd0);
    chk("single_we_after", 64'(ctrl_writeEnable), 64'd0);

    // Starvation: CPU writes every cycle
    cpu_set(1'b1, 5'd31);
    send_ev(5'd8, 32'h0000_1234);
    chk("starve_passthru_reg", 64'(ctrl_writeReg), 64'd31);
    blocked = 0;
    while (!cpu_stall && blocked < 40) begin
      blocked++;
      tick();
    end
    chk("starve_blocked_cycles", 64'(blocked), 64'd16);
    chk("force_we", 64'(ctrl_writeEnable), 64'd1);
    chk("force_port", {27'd0, ctrl_writeReg, data_writeReg}, {27'd0, 5'd8, 32'h0000_1234});
    tick();
    chk("force_stall_one_cycle", 64'(cpu_stall), 64'd0);
    chk("reissue_port", {31'd0, ctrl_writeEnable, ctrl_writeReg, data_writeReg},
        {31'd0, 1'b1, 5'd31, 8'hC0, 19'd0, 5'd31});
    chk("force_count0", 64'(fifo_count), 64'd0);

    // Fill to full with CPU busy, fifth event held
    cpu_set(1'b1, 5'd30);
    send_ev(5'd1, 32'h0000_0101);
    send_ev(5'd2, 32'h0000_0102);
    send_ev(5'd3, 32'h0000_0103);
    send_ev(5'd9, 32'h0000_0109);
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_ev_ready", 64'(ev_ready), 64'd0);
    chk("full_ovf_clear", 64'(ovf_sticky), 64'd0);
    send_ev(5'd10, 32'h0000_010A);
    chk("held_ovf_set", 64'(ovf_sticky), 64'd1);
    chk("held_count", 64'(fifo_count), 64'd4);
    cpu_set(1'b0, 5'd0);
    n = 0;
    while (fifo_count != 5'd0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(fifo_count), 64'd0);
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    // Events to register 0 are dropped
    for (int i = 0; i < 300; i++) send_ev(5'd0, 32'(i));
    tick();
    chk("drop_sat", 64'(drop_count), 64'd255);
    chk("drop_count0", 64'(fifo_count), 64'd0);
    chk("drop_ovf_sticky", 64'(ovf_sticky), 64'd1);

    // Wrap: back-to-back events, simultaneous push/pop each cycle
    for (int i = 0; i < 12; i++) begin
      send_ev(5'((i % 31) + 1), 32'h5A00_0000 | 32'(i));
      chk("wrap_count_const", 64'(fifo_count), 64'd1);
    end
    tick();
    chk("wrap_count0", 64'(fifo_count), 64'd0);
    chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while events are queued
    cpu_set(1'b1, 5'd20);
    send_ev(5'd4, 32'h0000_0204);
    send_ev(5'd6, 32'h0000_0206);
    send_ev(5'd7, 32'h0000_0207);
    chk("pre_reset_count", 64'(fifo_count), 64'd3);
    #2;
    ctrl_reset = 1'b1;
    #1;
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_ev_ready", 64'(ev_ready), 64'd1);
    chk("arst_passthru", {30'd0, cpu_stall, ctrl_writeEnable, ctrl_writeReg},
        {30'd0, 1'b0, 1'b1, 5'd20});
    exp_q.delete();
    @(negedge clock);
    #2;
    ctrl_reset = 1'b0;
    cpu_set(1'b0, 5'd0);
    for (int i = 0; i < 25; i++) tick();
    chk("post_reset_we", 64'(ctrl_writeEnable), 64'd0);
    chk("post_reset_flags", {ovf_sticky, drop_count}, 64'd0);
    chk("end_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
